// File: rtl/mem_pkg.sv
// Shared memory-access definitions: access size encoding, big-endian byte-lane
// mask and the default store-buffer depth.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    localparam int SB_DEPTH = 4;

    // Half wins when both select bits are set; neither means word.
    function automatic size_e size_dec(input logic half, input logic byt);
        if (half)     return SZ_HALF;
        else if (byt) return SZ_BYTE;
        else          return SZ_WORD;
    endfunction

    // Lane mask with byte 0 in the MSB position.
    function automatic logic [3:0] byte_mask(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_HALF: return a[1] ? 4'b0011 : 4'b1100;
            SZ_BYTE: return 4'b1000 >> a;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Overlap compare between one buffered store and the load in the memory stage.
// With STORE_BUFFER_FWD_EN defined, also flags a word-to-word forwardable hit.
module store_buffer_match
    import mem_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          vld_i,
    input  logic [AW-1:0] st_addr_i,
    input  size_e         st_size_i,
    input  logic [AW-1:0] ld_addr_i,
    input  size_e         ld_size_i,
`ifdef STORE_BUFFER_FWD_EN
    output logic          fwd_ok_o,
`endif
    output logic          hit_o
);

    logic same_word;

    assign same_word = (st_addr_i[AW-1:2] == ld_addr_i[AW-1:2]);
    assign hit_o     = vld_i && same_word &&
                       |(byte_mask(st_size_i, st_addr_i[1:0]) & byte_mask(ld_size_i, ld_addr_i[1:0]));

`ifdef STORE_BUFFER_FWD_EN
    assign fwd_ok_o = hit_o && (st_size_i == SZ_WORD) && (ld_size_i == SZ_WORD);
`endif

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer draining to the data-memory write port, with load
// hazard detection. Optional store-to-load word forwarding: STORE_BUFFER_FWD_EN.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic          st_half,
    input  logic          st_byte,
    input  logic [AW-1:0] ld_addr,
    input  logic          ld_half,
    input  logic          ld_byte,
    output logic          ld_hazard,
`ifdef STORE_BUFFER_FWD_EN
    output logic          ld_fwd_valid,
    output logic [31:0]   ld_fwd_data,
`endif
    output logic          mem_we,
    output logic [AW-1:0] mem_wa,
    output logic [31:0]   mem_wd,
    output logic          mem_half,
    output logic          mem_byte,
    input  logic          mem_hold,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        size_e         size;
    } entry_t;

    entry_t          ent_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   cnt_q, cnt_d;

    size_e           st_size, ld_size;
    logic [AW-1:0]   st_aln;
    logic            enq;
    entry_t          head;
    logic [DEPTH-1:0] ent_vld, hit;

    assign st_size  = size_dec(st_half, st_byte);
    assign ld_size  = size_dec(ld_half, ld_byte);
    assign st_ready = (cnt_q != CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign enq      = st_valid && st_ready;
    assign mem_we   = !empty && !mem_hold;
    assign head     = ent_q[head_q];

    always_comb begin
        st_aln = st_addr;
        if (st_size == SZ_HALF)      st_aln[0]   = 1'b0;
        else if (st_size == SZ_WORD) st_aln[1:0] = 2'b00;
    end

    assign mem_wa   = empty ? '0 : head.addr;
    assign mem_wd   = empty ? '0 : head.data;
    assign mem_half = !empty && (head.size == SZ_HALF);
    assign mem_byte = !empty && (head.size == SZ_BYTE);

    always_comb begin
        cnt_d = cnt_q;
        case ({enq, mem_we})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq)    tail_q <= tail_q + 1'b1;
            if (mem_we) head_q <= head_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Payload needs no reset: it is only observed through entries counted valid.
    always_ff @(posedge clk) begin
        if (enq) ent_q[tail_q] <= '{addr: st_aln, data: st_data, size: st_size};
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [DEPTH-1:0] fwd_ok;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PW-1:0] age;
        assign age        = PW'(i) - head_q;
        assign ent_vld[i] = ({1'b0, age} < cnt_q);

        store_buffer_match #(.AW(AW)) u_match (
            .vld_i     (ent_vld[i]),
            .st_addr_i (ent_q[i].addr),
            .st_size_i (ent_q[i].size),
            .ld_addr_i (ld_addr),
            .ld_size_i (ld_size),
`ifdef STORE_BUFFER_FWD_EN
            .fwd_ok_o  (fwd_ok[i]),
`endif
            .hit_o     (hit[i])
        );
    end

`ifdef STORE_BUFFER_FWD_EN
    logic          yng_fwd;
    logic [PW-1:0] yng_idx, idx;

    // Walk oldest to youngest so the last hit seen is the youngest one.
    always_comb begin
        yng_fwd = 1'b0;
        yng_idx = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (hit[idx]) begin
                yng_fwd = fwd_ok[idx];
                yng_idx = idx;
            end
        end
    end

    assign ld_fwd_valid = yng_fwd;
    assign ld_fwd_data  = yng_fwd ? ent_q[yng_idx].data : '0;
    assign ld_hazard    = (|hit) && !yng_fwd;
`else
    assign ld_hazard = |hit;
`endif

endmodule
